gate_sweep_checker: RTL and testbench



---
 rtl/gate_sweep_checker.sv | 152 +++++++++++++++
 tb/tb_gate_sweep_checker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every {a,b} pair into a gate block,
// checks all seven responses against the truth table, keeps a summary.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       and_out,
  input  logic       or_out,
  input  logic       nand_out,
  input  logic       nor_out,
  input  logic       xor_out,
  input  logic       xnor_out,
  input  logic       not_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [1:0] first_err_vec,
  output logic [6:0] first_err_mask
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE
  } state_e;

  localparam logic [3:0] LastSettle = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] LastPass   = 3'(NUM_PASSES - 1);

  state_e     state_q;
  logic [1:0] vec_q;
  logic [2:0] pcnt_q;
  logic [3:0] settle_q;
  logic       a_q;
  logic       b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_q;
  logic [1:0] fev_q;
  logic [6:0] fem_q;

  logic       va;
  logic       vb;
  logic [6:0] exp_d;
  logic [6:0] resp_d;
  logic [6:0] mask_d;
  logic       mism_d;

  // Expected responses for the vector on the wire, and per-output diffs
  always_comb begin
    va     = vec_q[1];
    vb     = vec_q[0];
    exp_d  = {va & vb, va | vb, ~(va & vb), ~(va | vb),
              va ^ vb, ~(va ^ vb), ~va};
    resp_d = {and_out, or_out, nand_out, nor_out,
              xor_out, xnor_out, not_out};
    mask_d = resp_d ^ exp_d;
    mism_d = |mask_d;
  end

  // Sweep FSM with registered stimulus and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= 2'd0;
      pcnt_q   <= 3'd0;
      settle_q <= 4'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 4'd0;
      fev_q    <= 2'd0;
      fem_q    <= 7'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= DRIVE;
            vec_q    <= 2'd0;
            pcnt_q   <= 3'd0;
            settle_q <= 4'd0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b1;
            pass_q   <= 1'b1;
            err_q    <= 4'd0;
            fev_q    <= 2'd0;
            fem_q    <= 7'd0;
          end
        end
        DRIVE: begin
          settle_q <= settle_q + 4'd1;
          if (settle_q == LastSettle) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (mism_d) begin
            pass_q <= 1'b0;
            if (err_q != 4'd15) begin
              err_q <= err_q + 4'd1;
            end
            // err_q is still zero only before the first recorded miss
            if (err_q == 4'd0) begin
              fev_q <= vec_q;
              fem_q <= mask_d;
            end
          end
          if (vec_q == 2'd3 && pcnt_q == LastPass) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q  <= DRIVE;
            settle_q <= 4'd0;
            vec_q    <= vec_q + 2'd1;
            a_q      <= va ^ vb;
            b_q      <= ~vb;
            if (vec_q == 2'd3) begin
              pcnt_q <= pcnt_q + 3'd1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a              = a_q;
  assign b              = b_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_vec  = fev_q;
  assign first_err_mask = fem_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed runs of the sweep checker against
// a modelled gate block with selectable faults.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_ok  = 0;

  // dut0: default parameters, fault-selectable gate model
  logic       start0 = 1'b0;
  int         fault0 = 0;
  logic       a0, b0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [1:0] fev0;
  logic [6:0] fem0;
  logic       g_and0, g_or0, g_nand0, g_nor0, g_xor0, g_xnor0, g_not0;

  assign g_and0  = a0 & b0;
  assign g_or0   = a0 | b0;
  assign g_nand0 = ~(a0 & b0);
  assign g_nor0  = ~(a0 | b0);
  assign g_xor0  = (fault0 == 1) ? 1'b0 : (a0 ^ b0);
  assign g_xnor0 = ~(a0 ^ b0);
  assign g_not0  = (fault0 == 2) ? a0 : ~a0;

  gate_sweep_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .a(a0), .b(b0),
    .and_out(g_and0), .or_out(g_or0), .nand_out(g_nand0),
    .nor_out(g_nor0), .xor_out(g_xor0), .xnor_out(g_xnor0),
    .not_out(g_not0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_vec(fev0), .first_err_mask(fem0)
  );

  // dut1: eight passes, and_out stuck at 1
  logic       start1 = 1'b0;
  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [1:0] fev1;
  logic [6:0] fem1;

  gate_sweep_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .a(a1), .b(b1),
    .and_out(1'b1), .or_out(a1 | b1), .nand_out(~(a1 & b1)),
    .nor_out(~(a1 | b1)), .xor_out(a1 ^ b1), .xnor_out(~(a1 ^ b1)),
    .not_out(~a1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_vec(fev1), .first_err_mask(fem1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One dut0 run; rp re-pulses start in DRIVE, CHECK and DONE
  task automatic run0(input bit rp, output int done_at, output int ndone);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    done_at = -1;
    ndone = 0;
    for (int j = 0; j < 20; j++) begin
      if (j < 12 && j % 3 == 0)
        chk($sformatf("vec%0d", j / 3), {30'd0, a0, b0}, j / 3);
      if (j == 0) chk("busy_start", {31'd0, busy0}, 1);
      if (done0) begin
        ndone++;
        if (done_at < 0) done_at = j;
        chk("busy_at_done", {31'd0, busy0}, 0);
      end
      start0 = rp && (j == 0 || j == 2 || j == 12);
      tick();
    end
    start0 = 1'b0;
  endtask

  task automatic res0(input string t, input logic p, input int e,
                      input int v, input int m);
    chk({t, "_pass"}, {31'd0, pass0}, {31'd0, p});
    chk({t, "_err"}, {28'd0, err0}, e);
    chk({t, "_fev"}, {30'd0, fev0}, v);
    chk({t, "_fem"}, {25'd0, fem0}, m);
  endtask

  int dat, nd, lat;

  initial begin
    tick();
    chk("rst_a", {31'd0, a0}, 0);
    chk("rst_busy", {31'd0, busy0}, 0);
    chk("rst_done", {31'd0, done0}, 0);
    chk("rst_pass", {31'd0, pass0}, 0);
    chk("rst_err", {28'd0, err0}, 0);
    chk("rst_fem", {25'd0, fem0}, 0);
    rst_n = 1'b1;
    tick();

    fault0 = 0;
    run0(1'b0, dat, nd);
    chk("clean_done_at", dat, 12);
    chk("clean_ndone", nd, 1);
    res0("clean", 1'b1, 0, 0, 0);

    fault0 = 1;
    run0(1'b0, dat, nd);
    chk("xor_done_at", dat, 12);
    res0("xor", 1'b0, 2, 1, 7'b0000100);

    fault0 = 0;
    run0(1'b1, dat, nd);
    chk("rp_done_at", dat, 12);
    chk("rp_ndone", nd, 1);
    chk("rp_busy", {31'd0, busy0}, 0);
    chk("rp_ab_hold", {30'd0, a0, b0}, 3);
    res0("rp", 1'b1, 0, 0, 0);

    fault0 = 2;
    run0(1'b0, dat, nd);
    res0("not", 1'b0, 4, 0, 7'b0000001);

    // Reset during the second CHECK, with one miss already recorded
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    chk("pre_rst_err", {28'd0, err0}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy0}, 0);
    chk("mid_rst_ab", {30'd0, a0, b0}, 0);
    chk("mid_rst_done", {31'd0, done0}, 0);
    res0("mid_rst", 1'b0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    fault0 = 0;
    nd = 0;
    for (int j = 0; j < 20; j++) begin
      if (done0 || busy0) nd++;
      tick();
    end
    chk("post_rst_idle", nd, 0);
    run0(1'b0, dat, nd);
    chk("post_rst_done_at", dat, 12);
    res0("post_rst", 1'b1, 0, 0, 0);

    // Eight passes with and_out stuck high
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 200) begin
      tick();
      lat++;
    end
    chk("np8_done_at", lat, 96);
    chk("np8_pass", {31'd0, pass1}, 0);
    chk("np8_err", {28'd0, err1}, 15);
    chk("np8_fev", {30'd0, fev1}, 0);
    chk("np8_fem", {25'd0, fem1}, 7'b1000000);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
